// File: rtl/signed_divmod_seq_pkg.sv
// Shared types for the iterative signed/unsigned divide-modulo unit.
// The result struct is sized at the datapath's standard 32-bit width.
package divmod_pkg;

  localparam int DIVMOD_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } divmod_state_t;

  typedef struct packed {
    logic [DIVMOD_W-1:0] quotient;
    logic [DIVMOD_W-1:0] remainder;
    logic                div_by_zero;
  } divmod_result_t;

endpackage

// File: rtl/signed_divmod_seq_if.sv
// Request/response handshake bundle of the divide-modulo unit.
interface signed_divmod_seq_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, is_signed, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, is_signed, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/signed_divmod_seq_step.sv
// One restoring-division step: shift in the next dividend bit and
// subtract the divisor magnitude when the difference does not borrow.
module divmod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_prem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_prem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_prem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_dvs};

  // Partial remainder stays below the divisor, so the result fits WIDTH bits.
  always_comb begin
    o_qbit = ~w_diff[WIDTH];
    if (o_qbit) begin
      o_prem = w_diff[WIDTH-1:0];
    end else begin
      o_prem = w_shift[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/signed_divmod_seq.sv
// Iterative divide/modulo unit: one restoring step per clock, results
// match SystemVerilog `/` and `%` in signed and unsigned modes.
module signed_divmod_seq
  import divmod_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  signed_divmod_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
  } result_t;

  divmod_state_t    r_state;
  divmod_state_t    w_state_nxt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_prem;
  logic [CW-1:0]    r_cnt;
  logic             r_sgn;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic             r_in_ready;
  logic             r_out_valid;
  result_t          r_res;
  logic [WIDTH-1:0] w_prem_nxt;
  logic             w_qbit;
  logic             w_dvs_zero;
  logic             w_dvd_neg;
  logic             w_dvs_neg;

  assign w_dvs_zero = (r_dvs == '0);
  assign w_dvd_neg  = r_sgn & r_quo[WIDTH-1];
  assign w_dvs_neg  = r_sgn & r_dvs[WIDTH-1];

  divmod_step #(.WIDTH(WIDTH)) u_step (
    .i_prem (r_prem),
    .i_bit  (r_quo[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_prem (w_prem_nxt),
    .o_qbit (w_qbit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; divide-by-zero still passes through FIX to give a two-edge latency.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) w_state_nxt = PREP;
        else              w_state_nxt = IDLE;
      end
      PREP: begin
        if (w_dvs_zero) w_state_nxt = FIX;
        else            w_state_nxt = RUN;
      end
      RUN: begin
        if (r_cnt == '0) w_state_nxt = FIX;
        else             w_state_nxt = RUN;
      end
      FIX:  w_state_nxt = DONE;
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
        else               w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Datapath: r_quo holds the dividend and shifts into the quotient as steps run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo   <= '0;
      r_dvs   <= '0;
      r_prem  <= '0;
      r_cnt   <= '0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_res   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_quo <= bus.dividend;
            r_dvs <= bus.divisor;
            r_sgn <= bus.is_signed;
            r_dbz <= 1'b0;
          end
        end
        PREP: begin
          r_cnt <= CW'(WIDTH - 1);
          if (w_dvs_zero) begin
            r_dbz   <= 1'b1;
            r_quo   <= '1;
            r_prem  <= r_quo;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
          end else begin
            r_quo   <= w_dvd_neg ? ('0 - r_quo) : r_quo;
            r_dvs   <= w_dvs_neg ? ('0 - r_dvs) : r_dvs;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
            r_prem  <= '0;
          end
        end
        RUN: begin
          r_quo  <= {r_quo[WIDTH-2:0], w_qbit};
          r_prem <= w_prem_nxt;
          r_cnt  <= r_cnt - CW'(1);
        end
        FIX: begin
          r_res.quotient    <= r_neg_q ? ('0 - r_quo) : r_quo;
          r_res.remainder   <= r_neg_r ? ('0 - r_prem) : r_prem;
          r_res.div_by_zero <= r_dbz;
        end
        DONE: begin
          r_res <= r_res;
        end
        default: begin
          r_res <= r_res;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_res.quotient;
  assign bus.remainder   = r_res.remainder;
  assign bus.div_by_zero = r_res.div_by_zero;

endmodule
